// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: bit positions, digit patterns (active-high, g..a in [6:0])
// and the polarity helper used on the final output bus.
package seg7_pkg;

    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'(1 << SEG_G);
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [7:0] seg_polarity(input logic [7:0] seg_ah, input logic active_low);
        return active_low ? ~seg_ah : seg_ah;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high segment pattern; non-BCD codes show a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_pattern
);

    always_comb begin
        o_pattern = SEG_DASH;
        case (i_nibble)
            4'd0:    o_pattern = SEG_0;
            4'd1:    o_pattern = SEG_1;
            4'd2:    o_pattern = SEG_2;
            4'd3:    o_pattern = SEG_3;
            4'd4:    o_pattern = SEG_4;
            4'd5:    o_pattern = SEG_5;
            4'd6:    o_pattern = SEG_6;
            4'd7:    o_pattern = SEG_7;
            4'd8:    o_pattern = SEG_8;
            4'd9:    o_pattern = SEG_9;
            default: o_pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scanner: double-buffered BCD word, guard-banded digit slots,
// registered seg/digits outputs one cycle behind the scan state; no backpressure (strobe input).
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*NUM_DIGITS-1:0] i_bcd_in,
    input  logic                    i_bcd_valid,
    input  logic [NUM_DIGITS-1:0]   i_dp_in,
    input  logic                    i_blank_lz,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_digits,
    output logic                    o_frame_done
);

    localparam int                CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int                IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic              ACT_LOW   = (ACTIVE_LOW != 0);
    localparam logic [7:0]        SEG_OFF   = seg_polarity(8'h00, ACT_LOW);
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{ACT_LOW}};

    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_frame_done;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic                    r_pend_vld;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   r_digits;

    logic                    w_slot_end;
    logic                    w_frame_end;
    logic                    w_in_guard;
    logic                    w_seg_load;
    logic [NUM_DIGITS-1:0]   w_lz;
    logic                    w_above_zero;
    logic [3:0]              w_nibble;
    logic                    w_dp;
    logic                    w_blank;
    logic [6:0]              w_pattern;
    logic [7:0]              w_seg_ah;
    logic [NUM_DIGITS-1:0]   w_digits_ah;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_in_guard  = (r_cnt < CNT_GUARD);
    // seg only reloads while the registered enables will be off, so a lit digit never glitches
    assign w_seg_load  = w_in_guard || (r_cnt == '0);

    // A digit is a leading zero when it and every digit above it is zero; digit 0 always shows.
    always_comb begin
        w_lz         = '0;
        w_above_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_above_zero = w_above_zero && (r_disp[4*k +: 4] == 4'd0);
            w_lz[k]      = w_above_zero;
        end
    end

    always_comb begin
        w_nibble = 4'd0;
        w_dp     = 1'b0;
        w_blank  = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_nibble = r_disp[4*k +: 4];
                w_dp     = i_dp_in[k];
                w_blank  = i_blank_lz && w_lz[k];
            end
        end
    end

    bcd_to_seg7 u_dec (
        .i_nibble  (w_nibble),
        .o_pattern (w_pattern)
    );

    always_comb begin
        w_seg_ah         = 8'h00;
        w_seg_ah[6:0]    = w_blank ? SEG_BLANK : w_pattern;
        w_seg_ah[SEG_DP] = w_dp;
        w_digits_ah      = '0;
        if (!w_in_guard) begin
            w_digits_ah[r_idx] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
            r_seg        <= SEG_OFF;
            r_digits     <= DIG_OFF;
        end else begin
            r_cnt        <= w_slot_end ? '0 : r_cnt + CNT_W'(1);
            if (w_slot_end) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
            end
            r_frame_done <= w_frame_end;
            if (w_seg_load) begin
                r_seg <= seg_polarity(w_seg_ah, ACT_LOW);
            end
            r_digits     <= ACT_LOW ? ~w_digits_ah : w_digits_ah;
        end
    end

    // A strobe coinciding with frame_end bypasses the pending stage so it shows next frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_disp     <= '0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            if (i_bcd_valid) begin
                r_pend <= i_bcd_in;
            end
            if (w_frame_end && i_bcd_valid) begin
                r_disp     <= i_bcd_in;
                r_pend_vld <= 1'b0;
            end else if (w_frame_end && r_pend_vld) begin
                r_disp     <= r_pend;
                r_pend_vld <= i_bcd_valid;
            end else if (i_bcd_valid) begin
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign o_seg        = r_seg;
    assign o_digits     = r_digits;
    assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-cycle slot, 1-cycle guard, 4 active-low digits.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [7:0]  seg;
    logic [3:0]  digits;
    logic        frame_done;

    int n_pass;
    int n_total;

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (4),
        .GUARD       (1),
        .ACTIVE_LOW  (1)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_bcd_in     (bcd_in),
        .i_bcd_valid  (bcd_valid),
        .i_dp_in      (dp_in),
        .i_blank_lz   (blank_lz),
        .o_seg        (seg),
        .o_digits     (digits),
        .o_frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_slot(input int k, output bit found);
        logic [3:0] tgt;
        tgt   = ~(4'b0001 << k);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (digits === tgt) found = 1'b1;
        end
    endtask

    task automatic wait_frame(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) found = 1'b1;
        end
    endtask

    task automatic pulse_valid(input logic [15:0] w);
        bcd_in    = w;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
    endtask

    task automatic load_word(input logic [15:0] w);
        bit found;
        pulse_valid(w);
        wait_frame(found);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bcd_in    = 16'h0000;
        bcd_valid = 1'b0;
        dp_in     = 4'h0;
        blank_lz  = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (seg !== 8'hFF || digits !== 4'hF || frame_done !== 1'b0)
            $display("FAIL reset_hold: seg=%h digits=%h fd=%b, expected seg=ff digits=f fd=0", seg, digits, frame_done);
        else n_pass++;
        pulse_valid(16'h1111);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if (digits !== 4'hF)
            $display("FAIL reset_first_guard: digits=%h, expected f", digits);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (digits !== 4'b1110 || seg !== 8'hC0)
            $display("FAIL reset_first_slot: seg=%h digits=%h, expected seg=c0 digits=e", seg, digits);
        else n_pass++;
    endtask

    task automatic test_capture();
        bit         found;
        logic [7:0] exp [4];
        exp = '{8'h99, 8'hB0, 8'hA4, 8'hF9};
        wait_frame(found);
        n_total++;
        if (!found) $display("FAIL capture_sync: frame_done=0, expected a pulse");
        else n_pass++;
        @(negedge clk);
        pulse_valid(16'h1234);
        wait_slot(1, found);
        n_total++;
        if (!found || seg !== 8'hC0)
            $display("FAIL capture_hold_d1: seg=%h found=%b, expected seg=c0", seg, found);
        else n_pass++;
        wait_slot(3, found);
        n_total++;
        if (!found || seg !== 8'hC0)
            $display("FAIL capture_hold_d3: seg=%h found=%b, expected seg=c0", seg, found);
        else n_pass++;
        wait_frame(found);
        for (int k = 0; k < 4; k++) begin
            wait_slot(k, found);
            n_total++;
            if (!found || seg !== exp[k])
                $display("FAIL capture_1234_d%0d: seg=%h found=%b, expected seg=%h", k, seg, found, exp[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit         found;
        logic [7:0] exp_a [4];
        logic [7:0] exp_b [4];
        exp_a = '{8'h90, 8'h92, 8'h90, 8'h92};
        exp_b = '{8'hA4, 8'hC0, 8'hF9, 8'hC0};
        wait_frame(found);
        repeat (15) @(negedge clk);
        pulse_valid(16'h5959);
        n_total++;
        if (frame_done !== 1'b1 || dut.r_pend_vld !== 1'b0)
            $display("FAIL b2b_same_cycle: fd=%b pend=%b, expected fd=1 pend=0", frame_done, dut.r_pend_vld);
        else n_pass++;
        @(negedge clk);
        pulse_valid(16'h0102);
        n_total++;
        if (dut.r_pend_vld !== 1'b1)
            $display("FAIL b2b_pending_set: pend=%b, expected 1", dut.r_pend_vld);
        else n_pass++;
        for (int k = 0; k < 4; k++) begin
            wait_slot(k, found);
            n_total++;
            if (!found || seg !== exp_a[k])
                $display("FAIL b2b_5959_d%0d: seg=%h found=%b, expected seg=%h", k, seg, found, exp_a[k]);
            else n_pass++;
        end
        wait_frame(found);
        for (int k = 0; k < 4; k++) begin
            wait_slot(k, found);
            n_total++;
            if (!found || seg !== exp_b[k])
                $display("FAIL b2b_0102_d%0d: seg=%h found=%b, expected seg=%h", k, seg, found, exp_b[k]);
            else n_pass++;
        end
    endtask

    task automatic test_blanking();
        bit          found;
        logic [15:0] words [3];
        logic [7:0]  exp   [3][4];
        words = '{16'h0007, 16'h0000, 16'h0507};
        exp   = '{'{8'hF8, 8'hFF, 8'hFF, 8'hFF},
                  '{8'hC0, 8'hFF, 8'hFF, 8'hFF},
                  '{8'hF8, 8'hC0, 8'h92, 8'hFF}};
        blank_lz = 1'b1;
        for (int w = 0; w < 3; w++) begin
            load_word(words[w]);
            for (int k = 0; k < 4; k++) begin
                wait_slot(k, found);
                n_total++;
                if (!found || seg !== exp[w][k])
                    $display("FAIL blank_%h_d%0d: seg=%h found=%b, expected seg=%h", words[w], k, seg, found, exp[w][k]);
                else n_pass++;
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_dash_dp();
        bit found;
        dp_in = 4'b0100;
        load_word(16'h0A00);
        wait_slot(0, found);
        n_total++;
        if (!found || seg !== 8'hC0)
            $display("FAIL dash_d0: seg=%h found=%b, expected seg=c0", seg, found);
        else n_pass++;
        wait_slot(2, found);
        n_total++;
        if (!found || seg !== 8'h3F)
            $display("FAIL dash_dp_d2: seg=%h found=%b, expected seg=3f", seg, found);
        else n_pass++;
        load_word(16'hF000);
        wait_slot(2, found);
        n_total++;
        if (!found || seg !== 8'h40)
            $display("FAIL zero_dp_d2: seg=%h found=%b, expected seg=40", seg, found);
        else n_pass++;
        wait_slot(3, found);
        n_total++;
        if (!found || seg !== 8'hBF)
            $display("FAIL dash_f_d3: seg=%h found=%b, expected seg=bf", seg, found);
        else n_pass++;
        dp_in = 4'b0000;
    endtask

    task automatic test_scan_guard();
        bit         found;
        logic [3:0] exp_dig;
        logic [3:0] prev_dig;
        logic [7:0] prev_seg;
        load_word(16'h1234);
        wait_frame(found);
        n_total++;
        if (!found) $display("FAIL scan_sync: frame_done=0, expected a pulse");
        else n_pass++;
        prev_dig = digits;
        prev_seg = seg;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            exp_dig = ((k - 1) % 4 == 0) ? 4'hF : ~(4'b0001 << (((k - 1) / 4) % 4));
            n_total++;
            if (digits !== exp_dig || $countones(~digits) > 1)
                $display("FAIL scan_digits_c%0d: digits=%h, expected %h", k, digits, exp_dig);
            else n_pass++;
            n_total++;
            if (frame_done !== (k % 16 == 0))
                $display("FAIL scan_frame_done_c%0d: fd=%b, expected %b", k, frame_done, (k % 16 == 0));
            else n_pass++;
            if (digits !== 4'hF && prev_dig !== 4'hF) begin
                n_total++;
                if (seg !== prev_seg)
                    $display("FAIL scan_seg_stable_c%0d: seg=%h, expected %h", k, seg, prev_seg);
                else n_pass++;
            end
            prev_dig = digits;
            prev_seg = seg;
        end
        wait_slot(2, found);
        #1 rst_n = 1'b0;
        #1;
        n_total++;
        if (!found || seg !== 8'hFF || digits !== 4'hF || frame_done !== 1'b0)
            $display("FAIL midreset_blank: seg=%h digits=%h fd=%b, expected seg=ff digits=f fd=0", seg, digits, frame_done);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if (digits !== 4'b1110 || seg !== 8'hC0)
            $display("FAIL midreset_restart: seg=%h digits=%h, expected seg=c0 digits=e", seg, digits);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n     = 1'b0;
        bcd_in    = 16'h0000;
        bcd_valid = 1'b0;
        dp_in     = 4'h0;
        blank_lz  = 1'b0;
        test_reset();
        test_capture();
        test_back_to_back();
        test_blanking();
        test_dash_dp();
        test_scan_guard();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
